// File: rtl/stopwatch_counter_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_counter_pkg
//   Shared definitions for the stopwatch counter slice:
//     - run/hold command encodings driven by the start/stop control FSM
//     - BCD digit limits for ones (0..9) and tens (0..5) positions
//     - prescaler width, wide enough for PRESCALE up to 2^27
//     - decoded mode enum plus a decode helper that folds the illegal
//       command 2'b11 into hold
// -----------------------------------------------------------------------------
package stopwatch_counter_pkg;

    localparam logic [1:0] EN_IDLE = 2'b00;
    localparam logic [1:0] EN_RUN  = 2'b01;
    localparam logic [1:0] EN_HOLD = 2'b10;

    localparam int unsigned BCD_ONES_MAX = 9;
    localparam int unsigned BCD_TENS_MAX = 5;

    localparam int unsigned PS_W = 27;

    typedef logic [PS_W-1:0] ps_t;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_HOLD = 2'b10
    } mode_e;

    // 2'b11 is not a legal command; it behaves exactly like hold.
    function automatic mode_e decode_mode(input logic [1:0] en);
        mode_e m;
        if (en == EN_IDLE) begin
            m = MODE_IDLE;
        end else if (en == EN_RUN) begin
            m = MODE_RUN;
        end else if (en == EN_HOLD) begin
            m = MODE_HOLD;
        end else begin
            m = MODE_HOLD;
        end
        return m;
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
//   One modulo-N BCD digit of the stopwatch display chain.
//
//   Parameters
//     N      modulus of the digit (10 for ones positions, 6 for tens)
//
//   Ports
//     clk    input   system clock, state on rising edge
//     rst_n  input   asynchronous active-low reset, clears the digit
//     clr    input   synchronous clear to 0 (takes priority over inc)
//     inc    input   advance the digit by one on the next edge
//     q      output  current digit value, registered
//     carry  output  combinational: inc is active while the digit sits at
//                    N-1, so the next digit in the chain advances on the
//                    same edge that this one returns to 0
// -----------------------------------------------------------------------------
module bcd_digit #(
    parameter int unsigned N = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    localparam logic [3:0] Q_MAX = 4'(N - 1);

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic       at_max;

    // ">=" rather than "==" so that a digit can never run past its limit,
    // whatever it holds.
    assign at_max = (q_q >= Q_MAX);
    assign carry  = inc && at_max;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (inc) begin
            q_d = at_max ? 4'd0 : (q_q + 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//   MM:SS stopwatch counting 00:00 .. 59:59 in BCD, advancing once every
//   PRESCALE clock cycles while the run command is applied.
//
//   Optional feature: define STOPWATCH_LAP_EN to add the lap input and the
//   lap-freeze display path. Without it, digit is always the live count.
//
//   Parameters
//     PRESCALE  clk cycles per one-second tick (2 .. 2^27)
//
//   Ports
//     clk    input        system clock, all state on rising edge
//     rst_n  input        asynchronous active-low reset
//     en     input  [1:0] 00 idle/clear, 01 run, 10 hold (11 treated as hold)
//     lap    input        single-cycle lap pulse (STOPWATCH_LAP_EN only)
//     digit  output [15:0] {min_tens, min_ones, sec_tens, sec_ones}, BCD
//     wrap   output       one-cycle pulse after 59:59 rolls to 00:00
// -----------------------------------------------------------------------------
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  en,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
`endif
    output logic [15:0] digit,
    output logic        wrap
);

    localparam ps_t PS_LAST = ps_t'(PRESCALE - 1);

    mode_e mode;
    logic  run;
    logic  clr;
    logic  tick;

    assign mode = decode_mode(en);
    assign run  = (mode == MODE_RUN);
    assign clr  = (mode == MODE_IDLE);

    // -------------------------------------------------------------------------
    // Prescaler: free-runs 0..PRESCALE-1 only in run, so a hold keeps the
    // partial second and the next run resumes from it.
    // -------------------------------------------------------------------------
    ps_t ps_q;
    ps_t ps_d;

    assign tick = run && (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q;
        case (mode)
            MODE_IDLE: ps_d = '0;
            MODE_RUN:  ps_d = (ps_q == PS_LAST) ? '0 : (ps_q + 1'b1);
            default:   ps_d = ps_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    // -------------------------------------------------------------------------
    // Digit chain. Carries are combinational, so every digit touched by a
    // tick updates on the same edge.
    // -------------------------------------------------------------------------
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       c_sec_ones;
    logic       c_sec_tens;
    logic       c_min_ones;
    logic       c_min_tens;

    bcd_digit #(.N(BCD_ONES_MAX + 1)) u_sec_ones (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (tick),
        .q     (sec_ones),
        .carry (c_sec_ones)
    );

    bcd_digit #(.N(BCD_TENS_MAX + 1)) u_sec_tens (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (c_sec_ones),
        .q     (sec_tens),
        .carry (c_sec_tens)
    );

    bcd_digit #(.N(BCD_ONES_MAX + 1)) u_min_ones (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (c_sec_tens),
        .q     (min_ones),
        .carry (c_min_ones)
    );

    bcd_digit #(.N(BCD_TENS_MAX + 1)) u_min_tens (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (c_min_ones),
        .q     (min_tens),
        .carry (c_min_tens)
    );

    logic [15:0] live;
    assign live = {min_tens, min_ones, sec_tens, sec_ones};

    // -------------------------------------------------------------------------
    // Wrap pulse: the final carry only exists on a tick at 59:59, so it is
    // registered alongside the digits' rollover. A clear never ticks, so it
    // can never raise wrap.
    // -------------------------------------------------------------------------
    logic wrap_q;
    logic wrap_d;

    assign wrap_d = c_min_tens;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

`ifdef STOPWATCH_LAP_EN
    // -------------------------------------------------------------------------
    // Lap freeze: the first lap in run captures the displayed count and holds
    // the display there while counting continues; the next lap releases it.
    // Idle drops the freeze; laps outside run are ignored.
    // -------------------------------------------------------------------------
    logic        freeze_q;
    logic        freeze_d;
    logic [15:0] snap_q;
    logic [15:0] snap_d;
    logic        lap_run;

    assign lap_run = lap && run;

    always_comb begin
        freeze_d = freeze_q;
        snap_d   = snap_q;
        if (clr) begin
            freeze_d = 1'b0;
            snap_d   = 16'h0000;
        end else if (lap_run) begin
            freeze_d = !freeze_q;
            if (!freeze_q) begin
                snap_d = live;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze_q <= 1'b0;
            snap_q   <= 16'h0000;
        end else begin
            freeze_q <= freeze_d;
            snap_q   <= snap_d;
        end
    end

    assign digit = freeze_q ? snap_q : live;
`else
    assign digit = live;
`endif

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000000, meaning clk cycles per 1 s count tick (legal range 2..2^27).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port en  input  2  run/hold command from the start/stop control FSM: 2'b00 idle/clear, 2'b01 run, 2'b10 hold.
REQ-005 SHALL have port lap  input  1  single-cycle lap pulse (present only with STOPWATCH_LAP_EN).
REQ-006 SHALL have port digit  output  16  display value {min_tens, min_ones, sec_tens, sec_ones}, 4-bit BCD each, registered.
REQ-007 SHALL have port wrap  output  1  one-cycle pulse when count rolls 59:59 -> 00:00, registered.

Function
REQ-010 SHALL contain a prescaler counter 0..PRESCALE-1; tick asserts for the one cycle in which prescaler == PRESCALE-1 and en == 2'b01.
REQ-011 In en == 2'b01, prescaler SHALL increment each cycle and return to 0 after PRESCALE-1.
REQ-012 In en == 2'b10 or en == 2'b11 (illegal, treated as hold), prescaler and all digits SHALL hold their values.
REQ-013 In en == 2'b00, prescaler and all digits SHALL clear to 0 on the next rising edge.
REQ-014 Transition hold -> run SHALL resume from the held prescaler value (no restart of the partial second).
REQ-015 On tick, sec_ones SHALL increment; 9 -> 0 carries to sec_tens; sec_tens 5 -> 0 carries to min_ones; min_ones 9 -> 0 carries to min_tens; min_tens 5 -> 0 completes wrap.
REQ-016 All digit updates from one tick SHALL land on the same clock edge (one-cycle latency from the tick cycle to the new digit value).
REQ-017 wrap SHALL assert in the cycle following the edge where 59:59 becomes 00:00, for exactly one cycle; it SHALL NOT assert on a clear via en == 2'b00.
REQ-018 Digit values SHALL never exceed 9 (ones) or 5 (tens), including after any en sequence.

Reset
REQ-020 While rst_n is low, prescaler, all digits, digit output, wrap and lap-freeze state SHALL be 0, independent of clk.
REQ-021 Reset asserted mid-count SHALL discard the partial second; counting resumes from 00:00 prescaler 0 once rst_n deasserts and en == 2'b01.

Configuration
REQ-030 Macro STOPWATCH_LAP_EN SHALL, when defined, add the lap port and a freeze flag: lap pulse in run toggles freeze; while frozen, digit holds the snapshot taken at the lap edge while internal counting continues; the second lap pulse releases freeze and digit tracks the live count on the next edge.
REQ-031 With STOPWATCH_LAP_EN, en == 2'b00 SHALL also clear the freeze flag; lap in hold or idle SHALL be ignored.
REQ-032 Without STOPWATCH_LAP_EN, the lap port and freeze logic SHALL be absent and digit SHALL always equal the live count.

Structure
REQ-040 A shared package SHALL hold the en encodings (EN_IDLE 2'b00, EN_RUN 2'b01, EN_HOLD 2'b10), the BCD limits (9, 5) and the prescaler width constant (27).
REQ-041 A sub-module bcd_digit SHALL implement one modulo-N BCD digit with inputs clk, rst_n, clr, inc and outputs q[3:0], carry; it SHALL be instantiated four times (N = 10, 6, 10, 6).

Verification (PRESCALE = 4 for simulation)
REQ-050 Reset then en = 01 for 40 cycles -> digit = 16'h0010 (10 s) and wrap never asserted.
REQ-051 Preload-by-run to 00:59, one more tick -> digit = 16'h0100; at 09:59 -> 16'h1000.
REQ-052 Run 2 cycles, en = 10 for 20 cycles, en = 01 for 2 cycles -> tick occurs exactly 4 run cycles after start; digit = 16'h0001.
REQ-053 Run to 59:59 then one tick -> digit = 16'h0000 and wrap high exactly one cycle; en = 00 at 12:34 -> digit = 16'h0000 next edge, wrap stays low.
REQ-054 rst_n pulsed low mid-cycle while digit = 16'h0005 -> digit = 16'h0000 immediately, before the next clk edge.
REQ-055 With STOPWATCH_LAP_EN: lap at 00:03, run 8 more ticks -> digit stays 16'h0003; second lap -> digit = 16'h0011 next edge.
